// File: rtl/mac_weight_bitplane_feeder_pkg.sv
// Shared constants and types for the weight bit-plane feeder of the bit-serial MAC.
package mac_pkg;

  localparam int DATA_WIDTH = 8;
  localparam int VEC_LENGTH = 16;
  localparam int COL_W      = $clog2(DATA_WIDTH);

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } feeder_state_t;

  // One two's-complement weight per lane; lane j is weight[j].
  typedef logic [VEC_LENGTH-1:0][DATA_WIDTH-1:0] weight_vec_t;

  // One bit per lane.
  typedef logic [VEC_LENGTH-1:0] bitplane_t;

  // Magnitude of a two's-complement value. The most negative value maps to
  // its own bit pattern (8'h80 -> 8'h80), which reads correctly as unsigned 128.
  function automatic logic [DATA_WIDTH-1:0] abs_mag(input logic [DATA_WIDTH-1:0] w);
    return w[DATA_WIDTH-1] ? (~w + 1'b1) : w;
  endfunction

endpackage

// File: rtl/mac_weight_bitplane_feeder_if.sv
// Weight-vector input handshake plus the column stream towards the MAC.
interface mac_weight_bitplane_feeder_if;
  import mac_pkg::*;

  logic              w_valid;
  logic              w_ready;
  weight_vec_t       weight;
  logic              out_ready;
  bitplane_t         sign;
  bitplane_t         w_bit;
  logic [COL_W-1:0]  column_idx;
  logic              en;
  logic              last;

  modport master (
    output w_valid, weight, out_ready,
    input  w_ready, sign, w_bit, column_idx, en, last
  );

  modport slave (
    input  w_valid, weight, out_ready,
    output w_ready, sign, w_bit, column_idx, en, last
  );

endinterface

// File: rtl/mac_weight_bitplane_feeder_msb_find.sv
// Leading-one detector over the column mask; also returns the mask with that bit cleared.
module bitplane_msb_find
  import mac_pkg::*;
(
  input  logic [DATA_WIDTH-1:0] mask,
  output logic [COL_W-1:0]      idx,
  output logic                  found,
  output logic [DATA_WIDTH-1:0] mask_next
);

  // Scan upward so the highest set bit is the last one to win.
  always_comb begin
    idx       = '0;
    found     = 1'b0;
    mask_next = mask;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      if (mask[i]) begin
        idx   = COL_W'(i);
        found = 1'b1;
      end
    end
    if (found) mask_next[idx] = 1'b0;
  end

endmodule

// File: rtl/mac_weight_bitplane_feeder.sv
// Converts a signed weight vector to sign-magnitude and streams its nonzero
// magnitude bit-columns MSB-first to the bit-serial MAC.
module mac_weight_bitplane_feeder
  import mac_pkg::*;
(
  input  logic                          clk,
  input  logic                          reset,
  mac_weight_bitplane_feeder_if.slave   fd
);

  feeder_state_t         state_q, state_d;
  logic [DATA_WIDTH-1:0] mask_q, mask_d;
  bitplane_t             sgn_q, sgn_d;
  weight_vec_t           mag_q, mag_d;
  logic                  en_q, en_d;
  logic                  last_q, last_d;
  logic [COL_W-1:0]      column_idx_q, column_idx_d;
  bitplane_t             w_bit_q, w_bit_d;
  bitplane_t             sign_q, sign_d;

  logic [COL_W-1:0]      msb_idx;
  logic                  msb_found;
  logic [DATA_WIDTH-1:0] mask_next;

  bitplane_msb_find u_msb_find (
    .mask      (mask_q),
    .idx       (msb_idx),
    .found     (msb_found),
    .mask_next (mask_next)
  );

  // Next-state and output logic: latch a vector in IDLE, issue one column per ready cycle in STREAM.
  always_comb begin
    state_d      = state_q;
    mask_d       = mask_q;
    sgn_d        = sgn_q;
    mag_d        = mag_q;
    en_d         = 1'b0;
    last_d       = 1'b0;
    column_idx_d = column_idx_q;
    w_bit_d      = w_bit_q;
    sign_d       = sign_q;

    case (state_q)
      IDLE: begin
        if (fd.w_valid) begin
          mask_d = '0;
          for (int j = 0; j < VEC_LENGTH; j++) begin
            sgn_d[j] = fd.weight[j][DATA_WIDTH-1];
            mag_d[j] = abs_mag(fd.weight[j]);
            mask_d   = mask_d | mag_d[j];
          end
          state_d = STREAM;
        end
      end
      STREAM: begin
        if (!msb_found) begin
          // All-zero vector: a lone last marks it as consumed, regardless of out_ready.
          last_d  = 1'b1;
          state_d = IDLE;
        end else if (fd.out_ready) begin
          en_d         = 1'b1;
          column_idx_d = msb_idx;
          sign_d       = sgn_q;
          for (int j = 0; j < VEC_LENGTH; j++) begin
            w_bit_d[j] = mag_q[j][msb_idx];
          end
          mask_d = mask_next;
          if (mask_next == '0) begin
            last_d  = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, working registers and registered column outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      mask_q       <= '0;
      sgn_q        <= '0;
      mag_q        <= '0;
      en_q         <= 1'b0;
      last_q       <= 1'b0;
      column_idx_q <= '0;
      w_bit_q      <= '0;
      sign_q       <= '0;
    end else begin
      state_q      <= state_d;
      mask_q       <= mask_d;
      sgn_q        <= sgn_d;
      mag_q        <= mag_d;
      en_q         <= en_d;
      last_q       <= last_d;
      column_idx_q <= column_idx_d;
      w_bit_q      <= w_bit_d;
      sign_q       <= sign_d;
    end
  end

  assign fd.w_ready    = (state_q == IDLE);
  assign fd.en         = en_q;
  assign fd.last       = last_q;
  assign fd.column_idx = column_idx_q;
  assign fd.w_bit      = w_bit_q;
  assign fd.sign       = sign_q;

endmodule

// File: tb/tb_mac_weight_bitplane_feeder.sv
// Bench for the weight bit-plane feeder: directed vectors, a mid-stream reset,
// and random vectors feeding a MAC model whose result must equal the dot product.
module tb_mac_weight_bitplane_feeder;
  import mac_pkg::*;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  mac_weight_bitplane_feeder_if bus ();

  mac_weight_bitplane_feeder dut (
    .clk   (clk),
    .reset (reset),
    .fd    (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic signed [DATA_WIDTH-1:0] act [VEC_LENGTH];
  logic [COL_W-1:0] held_col;
  bitplane_t        held_wbit;
  bitplane_t        held_sign;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic weight_vec_t rand_vec();
    weight_vec_t v;
    v = {$urandom, $urandom, $urandom, $urandom};
    return v;
  endfunction

  // Offer one vector, then stream it out while a MAC model accumulates.
  // mode 0: out_ready always high; 1: random out_ready; 2: two stall cycles after the first column.
  // reset_after > 0 asserts reset right after that many columns have been seen.
  task automatic run_vector(input weight_vec_t w, input int mode, input int reset_after);
    logic [DATA_WIDTH-1:0] mag [VEC_LENGTH];
    bitplane_t             sgn;
    bitplane_t             exp_wbit;
    logic [DATA_WIDTH-1:0] mask;
    int                    cols [$];
    longint                acc, ref_sum, term;
    int                    pulses, cycles, stall_left, c, v;
    logic                  rdy;
    bit                    done;

    mask    = '0;
    ref_sum = 0;
    for (int j = 0; j < VEC_LENGTH; j++) begin
      v        = $signed(w[j]);
      sgn[j]   = (v < 0);
      mag[j]   = (v < 0) ? DATA_WIDTH'(-v) : DATA_WIDTH'(v);
      mask     = mask | mag[j];
      ref_sum += longint'(v) * longint'(act[j]);
    end
    for (int b = DATA_WIDTH - 1; b >= 0; b--) if (mask[b]) cols.push_back(b);

    bus.w_valid = 1'b0;
    @(negedge clk);
    check("ready_idle", 64'(bus.w_ready), 64'd1);
    check("en_idle", 64'(bus.en), 64'd0);
    bus.w_valid = 1'b1;
    bus.weight  = w;
    @(negedge clk);
    bus.w_valid = 1'b0;
    bus.weight  = rand_vec();

    acc        = 0;
    pulses     = 0;
    cycles     = 0;
    stall_left = (mode == 2) ? 2 : 0;
    done       = 1'b0;
    while (!done) begin
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = ($urandom_range(0, 3) != 0);
        default: rdy = !(pulses == 1 && stall_left > 0);
      endcase
      if (mode == 2 && !rdy) stall_left--;
      bus.out_ready = rdy;
      bus.w_valid   = 1'($urandom_range(0, 1));
      bus.weight    = rand_vec();
      @(negedge clk);
      cycles++;
      if (cols.size() == 0) begin
        check("zero_last", 64'(bus.last), 64'd1);
        check("zero_en", 64'(bus.en), 64'd0);
        done = 1'b1;
      end else if (rdy) begin
        c = cols.pop_front();
        for (int j = 0; j < VEC_LENGTH; j++) exp_wbit[j] = mag[j][c];
        check("col_en", 64'(bus.en), 64'd1);
        check("col_idx", 64'(bus.column_idx), 64'(c));
        check("col_wbit", 64'(bus.w_bit), 64'(exp_wbit));
        check("col_sign", 64'(bus.sign), 64'(sgn));
        check("col_last", 64'(bus.last), 64'(cols.size() == 0));
        held_col  = COL_W'(c);
        held_wbit = exp_wbit;
        held_sign = sgn;
        pulses++;
        if (bus.en === 1'b1) begin
          for (int j = 0; j < VEC_LENGTH; j++) begin
            if (bus.w_bit[j]) begin
              term = longint'(act[j]) <<< bus.column_idx;
              acc  = bus.sign[j] ? acc - term : acc + term;
            end
          end
        end
        if (cols.size() == 0) done = 1'b1;
        if (!done && reset_after == pulses) begin
          bus.w_valid   = 1'b0;
          bus.out_ready = 1'b1;
          reset         = 1'b1;
          @(negedge clk);
          check("rst_en", 64'(bus.en), 64'd0);
          check("rst_last", 64'(bus.last), 64'd0);
          check("rst_ready", 64'(bus.w_ready), 64'd1);
          check("rst_col", 64'(bus.column_idx), 64'd0);
          reset     = 1'b0;
          held_col  = '0;
          held_wbit = '0;
          held_sign = '0;
          bus.out_ready = 1'b0;
          return;
        end
      end else begin
        check("stall_en", 64'(bus.en), 64'd0);
        check("stall_last", 64'(bus.last), 64'd0);
        check("stall_col", 64'(bus.column_idx), 64'(held_col));
        check("stall_wbit", 64'(bus.w_bit), 64'(held_wbit));
        check("stall_sign", 64'(bus.sign), 64'(held_sign));
      end
      if (!done && cycles > 300) begin
        n_tests++;
        n_fail++;
        $error("FAIL timeout: observed %0d cycles, required under 300", cycles);
        done = 1'b1;
      end
    end
    bus.w_valid   = 1'b0;
    bus.out_ready = 1'b0;

    check("end_ready", 64'(bus.w_ready), 64'd1);
    check("mac_result", 64'(acc), 64'(ref_sum));
    if (mask == '0) check("zero_cycles", 64'(cycles), 64'd1);
    else            check("pulse_count", 64'(pulses), 64'($countones(mask)));
  endtask

  initial begin
    weight_vec_t w;
    int r;

    bus.w_valid   = 1'b0;
    bus.out_ready = 1'b0;
    bus.weight    = '0;
    reset         = 1'b1;
    held_col      = '0;
    held_wbit     = '0;
    held_sign     = '0;
    for (int j = 0; j < VEC_LENGTH; j++) act[j] = 8'($urandom);

    repeat (2) @(negedge clk);
    check("reset_en", 64'(bus.en), 64'd0);
    check("reset_last", 64'(bus.last), 64'd0);
    check("reset_ready", 64'(bus.w_ready), 64'd1);
    check("reset_col", 64'(bus.column_idx), 64'd0);
    check("reset_wbit", 64'(bus.w_bit), 64'd0);
    check("reset_sign", 64'(bus.sign), 64'd0);
    reset = 1'b0;

    w = '0;
    run_vector(w, 0, 0);

    w = '0;
    w[0] = 8'd5;
    run_vector(w, 0, 0);

    w = '0;
    w[3] = 8'h80;
    run_vector(w, 0, 0);

    for (int j = 0; j < VEC_LENGTH; j++) w[j] = 8'(j + 1);
    run_vector(w, 2, 0);

    run_vector(w, 0, 2);

    for (int j = 0; j < VEC_LENGTH; j++) w[j] = 8'(-(j * 7));
    run_vector(w, 0, 0);

    for (int n = 0; n < 1000; n++) begin
      for (int j = 0; j < VEC_LENGTH; j++) begin
        act[j] = 8'($urandom);
        r = $urandom_range(0, 9);
        case (r)
          0:       w[j] = 8'h80;
          1:       w[j] = 8'h7f;
          2, 3:    w[j] = 8'h00;
          4:       w[j] = 8'($urandom_range(0, 3));
          default: w[j] = 8'($urandom);
        endcase
      end
      if (n % 97 == 5) w = '0;
      run_vector(w, (n % 3 == 0) ? 0 : 1, 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
